// File: rtl/eaglesong_pkg.sv
// rtl/eaglesong_pkg.sv - shared constants and types for the Eaglesong sponge controller
package eaglesong_pkg;

    localparam int STATE_WORDS = 16;
    localparam int RATE_WORDS  = 8;
    localparam logic [7:0] DELIM = 8'h06;
    localparam logic [31:0] PAD_WORD = {DELIM, 24'h000000};

    typedef logic [STATE_WORDS-1:0][31:0] state_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ABSORB,
        S_PAD,
        S_START,
        S_WAIT,
        S_SQUEEZE
    } sponge_state_e;

endpackage

// File: rtl/eaglesong_pad_word.sv
// rtl/eaglesong_pad_word.sv - formats one message word into the value XORed into the rate
module eaglesong_pad_word
    import eaglesong_pkg::*;
(
    input  logic [31:0] in_data,
    input  logic [2:0]  in_bytes,
    input  logic        in_last,
    output logic [31:0] pad_word,
    output logic        full_word
);

    always_comb begin
        full_word = !in_last || (in_bytes >= 3'd4);
        pad_word  = in_data;
        if (!full_word) begin
            // Short last word: keep the valid leading bytes, delimiter right after them
            case (in_bytes)
                3'd0:    pad_word = {DELIM, 24'h000000};
                3'd1:    pad_word = {in_data[31:24], DELIM, 16'h0000};
                3'd2:    pad_word = {in_data[31:16], DELIM, 8'h00};
                default: pad_word = {in_data[31:8], DELIM};
            endcase
        end
    end

endmodule

// File: rtl/eaglesong_sponge_ctrl.sv
// rtl/eaglesong_sponge_ctrl.sv - sponge absorb/pad/squeeze sequencer around the Eaglesong engine
module eaglesong_sponge_ctrl
    import eaglesong_pkg::*;
#(
    parameter int DIGEST_WORDS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       in_data,
    input  logic [2:0]        in_bytes,
    input  logic              in_last,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [31:0][15:0] perm_state_input,
    output logic              perm_start_eval,
    input  logic [31:0][15:0] perm_state_output,
    input  logic              perm_eval_output_ready,
    output logic [31:0]       out_data,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    localparam logic [2:0] LAST_K = 3'(DIGEST_WORDS - 1);

    sponge_state_e fsm;
    sponge_state_e fsm_nxt;
    state_t        st;
    logic [2:0]    w;
    logic [2:0]    k;
    logic          final_blk;
    logic          pad_pending;
    logic          wait_armed;

    logic [31:0]   pad_word;
    logic          full_word;
    logic          accept;
    logic          capture;
    logic          squeeze_done;

    eaglesong_pad_word u_pad_word (
        .in_data   (in_data),
        .in_bytes  (in_bytes),
        .in_last   (in_last),
        .pad_word  (pad_word),
        .full_word (full_word)
    );

    assign in_ready         = !rst && ((fsm == S_IDLE) || (fsm == S_ABSORB));
    assign accept           = in_valid && in_ready;
    // Engine ready may still be high from the previous run on the first WAIT cycle
    assign capture          = (fsm == S_WAIT) && wait_armed && perm_eval_output_ready;
    assign squeeze_done     = (fsm == S_SQUEEZE) && out_ready && (k == LAST_K);

    assign perm_state_input = st;
    assign perm_start_eval  = (fsm == S_START);
    assign out_valid        = (fsm == S_SQUEEZE);
    assign out_last         = out_valid && (k == LAST_K);
    assign out_data         = st[{1'b0, k}];
    assign busy             = (fsm != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm <= S_IDLE;
        end else begin
            fsm <= fsm_nxt;
        end
    end

    always_comb begin
        fsm_nxt = fsm;
        case (fsm)
            S_IDLE, S_ABSORB: begin
                if (accept) begin
                    if (!in_last) begin
                        fsm_nxt = (w == 3'd7) ? S_START : S_ABSORB;
                    end else if (!full_word) begin
                        fsm_nxt = S_START;
                    end else begin
                        fsm_nxt = (w == 3'd7) ? S_START : S_PAD;
                    end
                end
            end
            S_PAD:   fsm_nxt = S_START;
            S_START: fsm_nxt = S_WAIT;
            S_WAIT: begin
                if (capture) begin
                    if (final_blk) begin
                        fsm_nxt = S_SQUEEZE;
                    end else if (pad_pending) begin
                        fsm_nxt = S_PAD;
                    end else begin
                        fsm_nxt = S_ABSORB;
                    end
                end
            end
            S_SQUEEZE: begin
                if (squeeze_done) begin
                    fsm_nxt = S_IDLE;
                end
            end
            default: fsm_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st          <= '0;
            w           <= 3'd0;
            k           <= 3'd0;
            final_blk   <= 1'b0;
            pad_pending <= 1'b0;
            wait_armed  <= 1'b0;
        end else begin
            case (fsm)
                S_IDLE, S_ABSORB: begin
                    if (accept) begin
                        st[{1'b0, w}] <= st[{1'b0, w}] ^ pad_word;
                        w             <= w + 3'd1;
                        if (in_last && !full_word) begin
                            final_blk <= 1'b1;
                        end
                        // A full last word still owes a delimiter, in this block or the next
                        if (in_last && full_word) begin
                            pad_pending <= 1'b1;
                        end
                    end
                end
                S_PAD: begin
                    st[{1'b0, w}] <= st[{1'b0, w}] ^ PAD_WORD;
                    pad_pending   <= 1'b0;
                    final_blk     <= 1'b1;
                end
                S_START: begin
                    wait_armed <= 1'b0;
                end
                S_WAIT: begin
                    wait_armed <= 1'b1;
                    if (capture) begin
                        st <= perm_state_output;
                        w  <= 3'd0;
                    end
                end
                S_SQUEEZE: begin
                    if (out_ready) begin
                        k <= k + 3'd1;
                        if (k == LAST_K) begin
                            st        <= '0;
                            k         <= 3'd0;
                            final_blk <= 1'b0;
                        end
                    end
                end
                default: begin
                    w <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eaglesong_sponge_ctrl.sv
// tb/tb_eaglesong_sponge_ctrl.sv - scoreboard bench for the Eaglesong sponge controller
module tb_eaglesong_sponge_ctrl;
    import eaglesong_pkg::*;

    localparam int DW = 8;

    logic              clk;
    logic              rst;
    logic [31:0]       in_data;
    logic [2:0]        in_bytes;
    logic              in_last;
    logic              in_valid;
    logic              in_ready;
    logic [31:0][15:0] perm_state_input;
    logic              perm_start_eval;
    logic [31:0][15:0] perm_state_output;
    logic              perm_eval_output_ready;
    logic [31:0]       out_data;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;

    state_t      start_q[$];
    logic [31:0] dig_q[$];
    logic        last_q[$];
    logic [7:0]  msg[$];

    int          start_cnt = 0;
    int          xfer_cnt  = 0;
    int          last_cnt  = 0;
    int          bp_mode   = 0;
    int          bp_idx    = 0;
    logic        held      = 1'b0;
    logic [31:0] held_data = '0;
    logic        held_last = 1'b0;

    eaglesong_sponge_ctrl #(.DIGEST_WORDS(DW)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .in_data                (in_data),
        .in_bytes               (in_bytes),
        .in_last                (in_last),
        .in_valid               (in_valid),
        .in_ready               (in_ready),
        .perm_state_input       (perm_state_input),
        .perm_start_eval        (perm_start_eval),
        .perm_state_output      (perm_state_output),
        .perm_eval_output_ready (perm_eval_output_ready),
        .out_data               (out_data),
        .out_last               (out_last),
        .out_valid              (out_valid),
        .out_ready              (out_ready),
        .busy                   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic state_t perm_f(input state_t s);
        state_t r;
        for (int i = 0; i < 16; i++) begin
            r[i] = {s[i][26:0], s[i][31:27]} ^ s[(i + 3) % 16] ^ 32'(32'h9e3779b9 * (i + 1));
        end
        return r;
    endfunction

    // Stand-in engine: random latency, stale ready held across the start edge
    state_t eng_in;
    state_t eng_out = {16{32'hdeadbeef}};
    logic   eng_rdy = 1'b1;
    logic   start_d = 1'b0;
    int     eng_cnt = 0;
    assign perm_state_output      = eng_out;
    assign perm_eval_output_ready = eng_rdy;

    always @(posedge clk) begin
        start_d <= perm_start_eval;
        if (perm_start_eval) eng_in <= perm_state_input;
        if (start_d) begin
            eng_cnt <= $urandom_range(1, 12);
            eng_rdy <= 1'b0;
        end else if (eng_cnt != 0) begin
            eng_cnt <= eng_cnt - 1;
            if (eng_cnt == 1) begin
                eng_out <= perm_f(eng_in);
                eng_rdy <= 1'b1;
            end
        end
    end

    // Output sink and scoreboard
    initial begin
        state_t got;
        state_t exp_s;
        logic [31:0] exp_d;
        logic exp_l;
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            out_ready = (bp_mode != 0) ? (bp_idx % 3 == 0) : 1'b1;
            if (held && out_valid) begin
                n_checks++;
                if (out_data !== held_data || out_last !== held_last) begin
                    n_fail++;
                    $display("FAIL stall_stable: got %h/%b want %h/%b", out_data, out_last, held_data, held_last);
                end
            end
            if (out_valid && out_ready && !rst) begin
                xfer_cnt++;
                if (out_last) last_cnt++;
                n_checks++;
                if (dig_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_digest: got %h want none", out_data);
                end else begin
                    exp_d = dig_q.pop_front();
                    exp_l = last_q.pop_front();
                    if (out_data !== exp_d || out_last !== exp_l) begin
                        n_fail++;
                        $display("FAIL digest_word: got %h/%b want %h/%b", out_data, out_last, exp_d, exp_l);
                    end
                end
            end
            held      = out_valid && !out_ready && !rst;
            held_data = out_data;
            held_last = out_last;
            if (out_valid) bp_idx++;
            if (perm_start_eval && !rst) begin
                start_cnt++;
                got = perm_state_input;
                n_checks++;
                if (start_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_start: got %h want none", got);
                end else begin
                    exp_s = start_q.pop_front();
                    if (got !== exp_s) begin
                        n_fail++;
                        $display("FAIL start_state: got %h want %h", got, exp_s);
                    end
                end
            end
        end
    end

    task automatic send_msg(input logic [7:0] m[$]);
        int len;
        int nblk;
        int nw;
        int t;
        logic [7:0] padded[$];
        logic [7:0] b[4];
        state_t s;
        len  = m.size();
        nblk = len / 32 + 1;
        padded = m;
        padded.push_back(DELIM);
        while (padded.size() < nblk * 32) padded.push_back(8'h00);
        s = '0;
        for (int bi = 0; bi < nblk; bi++) begin
            for (int j = 0; j < RATE_WORDS; j++) begin
                s[j] = s[j] ^ {padded[bi*32+4*j], padded[bi*32+4*j+1],
                               padded[bi*32+4*j+2], padded[bi*32+4*j+3]};
            end
            start_q.push_back(s);
            s = perm_f(s);
        end
        for (int i = 0; i < DW; i++) begin
            dig_q.push_back(s[i]);
            last_q.push_back(i == DW - 1);
        end
        nw = (len == 0) ? 1 : (len + 3) / 4;
        for (int wi = 0; wi < nw; wi++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) b[i] = (4*wi + i < len) ? m[4*wi+i] : 8'ha5;
            in_data  = {b[0], b[1], b[2], b[3]};
            in_last  = (wi == nw - 1);
            in_bytes = (wi == nw - 1) ? 3'(len - 4*wi) : 3'($urandom);
            in_valid = 1'b1;
            t = 0;
            while (!in_ready && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (t >= 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL in_ready_timeout: got 0 want 1");
            end
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL in_ready_after_last: got %b want 0", in_ready);
        end
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (dig_q.size() != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        n_checks++;
        if (t >= 3000) begin
            n_fail++;
            $display("FAIL digest_timeout: got %0d left want 0", dig_q.size());
        end
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_squeeze: got busy=%b out_valid=%b want 0 0", busy, out_valid);
        end
        n_checks++;
        if (start_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_start: got %0d pending want 0", start_q.size());
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_checks++;
        if (in_ready !== 1'b0 || perm_start_eval !== 1'b0 || out_valid !== 1'b0 ||
            out_last !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_ctrl: got rdy=%b start=%b ov=%b ol=%b busy=%b want all 0",
                     tag, in_ready, perm_start_eval, out_valid, out_last, busy);
        end
        n_checks++;
        if (out_data !== 32'h0 || perm_state_input !== '0) begin
            n_fail++;
            $display("FAIL %s_data: got out=%h st0=%h want 0", tag, out_data, perm_state_input[1:0]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got rdy=%b busy=%b want 1 0", in_ready, busy);
        end
    endtask

    task automatic test_empty();
        msg.delete();
        start_cnt = 0;
        send_msg(msg);
        wait_done();
        n_checks++;
        if (start_cnt != 1) begin
            n_fail++;
            $display("FAIL empty_starts: got %0d want 1", start_cnt);
        end
    endtask

    task automatic test_abc();
        msg = '{8'h61, 8'h62, 8'h63};
        send_msg(msg);
        wait_done();
    endtask

    task automatic test_len(input int n, input int nblk);
        msg.delete();
        for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
        start_cnt = 0;
        send_msg(msg);
        wait_done();
        n_checks++;
        if (start_cnt != nblk) begin
            n_fail++;
            $display("FAIL starts_len%0d: got %0d want %0d", n, start_cnt, nblk);
        end
    endtask

    task automatic test_backpressure();
        bp_mode = 1;
        bp_idx = 0;
        xfer_cnt = 0;
        last_cnt = 0;
        msg = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        send_msg(msg);
        wait_done();
        n_checks++;
        if (xfer_cnt != DW || last_cnt != 1) begin
            n_fail++;
            $display("FAIL bp_counts: got xfer=%0d last=%0d want %0d 1", xfer_cnt, last_cnt, DW);
        end
        bp_mode = 0;
    endtask

    task automatic test_back_to_back();
        start_cnt = 0;
        msg.delete();
        for (int i = 0; i < 40; i++) msg.push_back(8'($urandom));
        send_msg(msg);
        wait_done();
        msg.delete();
        for (int i = 0; i < 7; i++) msg.push_back(8'($urandom));
        send_msg(msg);
        wait_done();
        n_checks++;
        if (start_cnt != 3) begin
            n_fail++;
            $display("FAIL b2b_starts: got %0d want 3", start_cnt);
        end
    endtask

    task automatic test_reset_in_wait();
        msg = '{8'h61, 8'h62, 8'h63};
        send_msg(msg);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || perm_start_eval !== 1'b0) begin
            n_fail++;
            $display("FAIL in_wait: got busy=%b start=%b want 1 0", busy, perm_start_eval);
        end
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst_wait");
        rst = 1'b0;
        dig_q.delete();
        last_q.delete();
        start_q.delete();
        start_cnt = 0;
        msg = '{8'h61, 8'h62, 8'h63};
        send_msg(msg);
        wait_done();
        n_checks++;
        if (start_cnt != 1) begin
            n_fail++;
            $display("FAIL abort_starts: got %0d want 1", start_cnt);
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_data  = '0;
        in_bytes = '0;
        in_last  = 1'b0;
        in_valid = 1'b0;
        test_reset();
        test_empty();
        test_abc();
        test_len(32, 2);
        test_len(36, 2);
        test_len(31, 1);
        test_backpressure();
        test_back_to_back();
        test_reset_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/eaglesong_sponge_ctrl.md
Name: eaglesong_sponge_ctrl

Overview:
Sponge-mode initiator for the iterative Eaglesong permutation engine: absorbs a byte-granular message stream and applies Eaglesong padding. It drives the engine's start/state handshake once per 256-bit rate block, then squeezes the digest as a word stream. It sits between the message source and the permutation engine inside the top-level hash wrapper.

Parameters:
DIGEST_WORDS, 8, number of 32-bit digest words emitted (1..8; one squeeze block only, no extra permutation).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_data  in  32  message word, first byte in bits [31:24]
in_bytes  in  3  valid bytes in a last word, 0..4, MSB-first; ignored (treated as 4) when in_last=0
in_last  in  1  final message word
in_valid  in  1  input word valid
in_ready  out  1  controller accepts the word this cycle
perm_state_input  out  32 x [15:0]  state presented to the engine; stable from the start cycle until the engine reports ready
perm_start_eval  out  1  one-cycle start pulse to the engine
perm_state_output  in  32 x [15:0]  engine result, valid when perm_eval_output_ready=1
perm_eval_output_ready  in  1  engine done; undefined until the engine's first start
out_data  out  32  digest word
out_last  out  1  marks word DIGEST_WORDS-1
out_valid  out  1  digest word valid
out_ready  in  1  sink accepts the word
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (synchronous, active-high): FSM to IDLE; state regs all 0; word index 0; pad_pending 0. Outputs in_ready=0, perm_start_eval=0, out_valid=0, out_last=0, busy=0. out_data and perm_state_input show the zeroed state.
- Reset mid-operation (any state) aborts. The engine has no reset and may keep running; the controller ignores perm_eval_output_ready until after its next start pulse.
- FSM states: IDLE, ABSORB, PAD, START, WAIT, SQUEEZE.
- IDLE: state zeroed, in_ready=1. The first accepted word is processed as in ABSORB, and the FSM moves to ABSORB.
- ABSORB: in_ready=1. On each accepted word, state[w] ^= formatted word and w increments.
  - Non-last word: XOR raw data. At w=7, go to START with final=0.
  - Last word, in_bytes=b<4: keep bytes 0..b-1, put 0x06 in byte b, zero the rest (b=0 gives 0x06000000). Set final=1. Go to START, since the remaining words XOR with zero.
  - Last word, b=4: XOR raw data and set pad_pending. If w<7, go to PAD; if w=7, go to START with final=0.
- PAD: in_ready=0. Set state[w] ^= 0x06000000, clear pad_pending, set final=1, go to START.
- START: perm_start_eval=1 for exactly one cycle, with perm_state_input = state. Go to WAIT.
- WAIT: ignore ready on the first WAIT cycle. When perm_eval_output_ready=1, capture state <= perm_state_output and set w=0.
  - final=1: go to SQUEEZE.
  - pad_pending=1: go to PAD.
  - Otherwise: go to ABSORB.
  - No fixed latency is assumed (the current engine takes about 44 cycles).
- SQUEEZE: out_valid=1, out_data=state[k] with k from 0 to DIGEST_WORDS-1. k advances only on out_valid&&out_ready. out_data and out_last are held stable while stalled. After the last word transfers: zero the state and go to IDLE.
- in_ready is 0 in PAD, START, WAIT and SQUEEZE. A new message is not accepted until IDLE.
- Per-block cost with a continuous input stream: 8 accept cycles + 1 START + engine latency + 1 capture.

Decomposition:
- eaglesong_pkg:
  - STATE_WORDS=16, RATE_WORDS=8, DELIM=8'h06.
  - typedef state_t (16 x 32-bit).
  - enum sponge_state_e.
- Sub-module eaglesong_pad_word: combinational formatter mapping (in_data, in_bytes, in_last) to the XOR word.
- The engine is instantiated beside this block in the top wrapper, not inside it.

Test Plan:
- Empty message (in_last=1, in_bytes=0): first START shows perm_state_input[0]=0x06000000 and words 1..15 = 0 → one permutation, 8 digest words matching the C model.
- "abc" (in_data=0x61626300, in_bytes=3) → start state[0]=0x61626306, others 0; digest matches the C model.
- 32-byte message (8 full words, last b=4) → two permutations; second START state[0] = perm_output[0]^0x06000000, words 1..7 = perm_output[1..7].
- 36-byte message (9 words, last b=4) → 2nd block state[0] = out[0]^data8, state[1] = out[1]^0x06000000 via PAD; in_ready low during PAD.
- Squeeze backpressure: out_ready toggled 1,0,0,1,... → each word stays stable, exactly 8 transfers, out_last only on the 8th, then busy=0.
- rst asserted in WAIT → next cycle all outputs at reset values. A following "abc" message still produces the correct digest, with perm_start_eval pulsing exactly once per block.
